// File: rtl/ctrl_pkg.sv
// Shared definitions for the ctrl_fsm control unit: step encoding, opcodes,
// IR field positions and the registered output bundle.
package ctrl_pkg;

  localparam int IR_W  = 9;
  localparam int SEL_W = 10;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;

  localparam int SEL_G   = 8;
  localparam int SEL_DIN = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    TRAP = 3'd4
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [7:0]       rin;
    logic             ain;
    logic             gin;
    logic             addsub;
    logic             done;
  } ctrl_out_t;

  // Opcodes 100..111 have no defined instruction.
  function automatic logic is_illegal(input logic [2:0] op);
    return op > OP_SUB;
  endfunction

endpackage

// File: rtl/ctrl_dec3to8.sv
// 3-to-8 one-hot decoder used for the Rx and Ry register fields.
module ctrl_dec3to8 (
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  assign onehot = 8'b1 << idx;

endmodule

// File: rtl/ctrl_fsm.sv
// Instruction sequencer for the 16-bit CPU datapath (steps T0..T3).
// Define CTRL_ILLEGAL_TRAP_EN to lock up in TRAP on an illegal opcode.
import ctrl_pkg::*;

module ctrl_fsm (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iRun,
  input  logic [15:0]      iDIN,
  output logic [SEL_W-1:0] oSel,
  output logic [7:0]       oRin,
  output logic             oAin,
  output logic             oGin,
  output logic             oAddSub,
  output logic             oDone,
  output logic             oIllegal
);

  state_t          state, state_next;
  logic [IR_W-1:0] ir, ir_next;
  logic [2:0]      op_next;
  logic [7:0]      rx_oh, ry_oh;
  ctrl_out_t       out_next, out_q;
  logic            unused_din_hi;

  assign unused_din_hi = ^iDIN[15:IR_W];
  assign op_next       = ir_next[OP_HI:OP_LO];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    ir_next    = ir;
    case (state)
      T0: if (iRun) begin
        ir_next    = iDIN[IR_W-1:0];
        state_next = T1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (is_illegal(iDIN[OP_HI:OP_LO])) state_next = TRAP;
`endif
      end
      T1: begin
        if (ir[OP_HI:OP_LO] == OP_ADD || ir[OP_HI:OP_LO] == OP_SUB) state_next = T2;
        else state_next = T0;
      end
      T2:      state_next = T3;
      T3:      state_next = T0;
      TRAP:    state_next = TRAP;
      default: state_next = T0;
    endcase
  end

  ctrl_dec3to8 u_dec_rx (.idx(ir_next[RX_HI:RX_LO]), .onehot(rx_oh));
  ctrl_dec3to8 u_dec_ry (.idx(ir_next[RY_HI:RY_LO]), .onehot(ry_oh));

  // Outputs are decoded for the step about to be entered and then registered,
  // so each step's controls appear from a flop with no path from iRun/iDIN.
  always_comb begin
    out_next = '0;
    case (state_next)
      T1: begin
        case (op_next)
          OP_MV: begin
            out_next.sel  = {2'b00, ry_oh};
            out_next.rin  = rx_oh;
            out_next.done = 1'b1;
          end
          OP_MVI: begin
            out_next.sel[SEL_DIN] = 1'b1;
            out_next.rin          = rx_oh;
            out_next.done         = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            out_next.sel = {2'b00, rx_oh};
            out_next.ain = 1'b1;
          end
          default: out_next.done = 1'b1;
        endcase
      end
      T2: begin
        out_next.sel    = {2'b00, ry_oh};
        out_next.gin    = 1'b1;
        out_next.addsub = (op_next == OP_SUB);
      end
      T3: begin
        out_next.sel[SEL_G] = 1'b1;
        out_next.rin        = rx_oh;
        out_next.done       = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= T0;
      ir    <= '0;
      out_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state <= state_next;
      ir    <= ir_next;
      out_q <= out_next;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_q | (state_next == TRAP);
`endif
    end
  end

  assign oSel    = out_q.sel;
  assign oRin    = out_q.rin;
  assign oAin    = out_q.ain;
  assign oGin    = out_q.gin;
  assign oAddSub = out_q.addsub;
  assign oDone   = out_q.done;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign oIllegal = illegal_q;
`else
  assign oIllegal = 1'b0;
`endif

endmodule
